ram_access_ctrl: RTL and testbench

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

---
 rtl/ram_access_ctrl_pkg.sv | 15 +
 rtl/ram_access_ctrl_if.sv | 37 +++
 rtl/ram_access_ctrl_arb.sv | 36 +++
 rtl/ram_access_ctrl.sv | 115 +++++++++++
 tb/tb_ram_access_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and default geometry for the RAM access controller.
// Imported by the interface, the arbiter and the top.
package ram_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int RAM_DEPTH      = 2 ** DEF_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Producer, host, scan and RAM-drive signals of ram_access_ctrl.
// The controller takes the slave modport; its environment takes master.
interface ram_access_ctrl_if
   import ram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

   logic                  req_a, req_b;
   logic [ADDR_WIDTH-1:0] addr_a, addr_b;
   logic [DATA_WIDTH-1:0] data_a, data_b;
   logic                  gnt_a, gnt_b;
   logic [ADDR_WIDTH-1:0] host_r_s1, host_r_s2, host_r_s3;
   logic                  scan_start;
   logic                  scan_busy, scan_done;
   logic [ADDR_WIDTH-1:0] scan_idx;
   logic                  ram_wr_en;
   logic [ADDR_WIDTH-1:0] ram_w_s;
   logic [DATA_WIDTH-1:0] ram_w_d;
   logic [ADDR_WIDTH-1:0] ram_r_s1, ram_r_s2, ram_r_s3;

   modport master (
      output req_a, req_b, addr_a, addr_b, data_a, data_b,
      output host_r_s1, host_r_s2, host_r_s3, scan_start,
      input  gnt_a, gnt_b, scan_busy, scan_done, scan_idx,
      input  ram_wr_en, ram_w_s, ram_w_d, ram_r_s1, ram_r_s2, ram_r_s3
   );

   modport slave (
      input  req_a, req_b, addr_a, addr_b, data_a, data_b,
      input  host_r_s1, host_r_s2, host_r_s3, scan_start,
      output gnt_a, gnt_b, scan_busy, scan_done, scan_idx,
      output ram_wr_en, ram_w_s, ram_w_d, ram_r_s1, ram_r_s2, ram_r_s3
   );

endinterface

// File: rtl/ram_access_ctrl_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant while enabled,
// with a register remembering which requester won last.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic last_a_q;  // 1 when requester A won the latest grant

   always_comb begin
      // NOTE: default first so no path leaves gnt_o unassigned (no latch).
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_i[0] && (!req_i[1] || !last_a_q)) begin
            gnt_o = 2'b01;
         end else if (req_i[1]) begin
            gnt_o = 2'b10;
         end
      end
   end

   // NOTE: registers use <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_a_q <= 1'b0;
      end else if (gnt_o[0]) begin
         last_a_q <= 1'b1;
      end else if (gnt_o[1]) begin
         last_a_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// Write arbitration for two producers plus host / full-scan read-address
// drive for a RAM32-style macro; scans lock out writes until back in IDLE.
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   ram_access_ctrl_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ROW_MASK = ~ADDR_WIDTH'(3);

   state_e                state_q, state_d;
   logic [1:0]            gnt;
   logic                  arb_en;
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] w_s_q;
   logic [DATA_WIDTH-1:0] w_d_q;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] r_s1_q, r_s1_d, r_s2_q, r_s2_d, r_s3_q, r_s3_d;

   assign arb_en = (state_q == IDLE) && !reset;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en_i  (arb_en),
      .req_i ({bus.req_b, bus.req_a}),
      .gnt_o (gnt)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.scan_start) state_d = SCAN;
         SCAN:    if (idx_q == LAST_IDX) state_d = DRAIN;
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read addresses are computed for the coming state so they leave a flop.
   always_comb begin
      idx_d  = '0;
      r_s1_d = r_s1_q;
      r_s2_d = r_s2_q;
      r_s3_d = r_s3_q;
      case (state_d)
         SCAN: begin
            idx_d  = (state_q == SCAN) ? idx_q + ADDR_WIDTH'(1) : '0;
            r_s1_d = idx_d;
            r_s2_d = idx_d & ROW_MASK;
            r_s3_d = '0;
         end
         DRAIN: idx_d = idx_q;
         default: begin
            if (state_q == IDLE) begin
               r_s1_d = bus.host_r_s1;
               r_s2_d = bus.host_r_s2;
               r_s3_d = bus.host_r_s3;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         r_s1_q  <= '0;
         r_s2_q  <= '0;
         r_s3_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         r_s1_q  <= r_s1_d;
         r_s2_q  <= r_s2_d;
         r_s3_q  <= r_s3_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q <= 1'b0;
         w_s_q   <= '0;
         w_d_q   <= '0;
      end else begin
         wr_en_q <= |gnt;
         if (gnt[0]) begin
            w_s_q <= bus.addr_a;
            w_d_q <= bus.data_a;
         end else if (gnt[1]) begin
            w_s_q <= bus.addr_b;
            w_d_q <= bus.data_b;
         end
      end
   end

   assign bus.gnt_a     = gnt[0];
   assign bus.gnt_b     = gnt[1];
   assign bus.scan_busy = (state_q != IDLE);
   assign bus.scan_done = (state_q == DRAIN);
   assign bus.scan_idx  = idx_q;
   assign bus.ram_wr_en = wr_en_q;
   assign bus.ram_w_s   = w_s_q;
   assign bus.ram_w_d   = w_d_q;
   assign bus.ram_r_s1  = r_s1_q;
   assign bus.ram_r_s2  = r_s2_q;
   assign bus.ram_r_s3  = r_s3_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized bench for ram_access_ctrl: a cycle-level model queues expected
// events with their due cycle; a negedge monitor pops and compares them.
module tb_ram_access_ctrl;
   import ram_ctrl_pkg::*;

   localparam int DW    = DEF_DATA_WIDTH;
   localparam int AW    = DEF_ADDR_WIDTH;
   localparam int DEPTH = RAM_DEPTH;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ram_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ram_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          due;
      logic [63:0] val;
   } exp_t;

   exp_t gnt_q[$], wr_q[$], scan_q[$], done_q[$], host_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference-model state
   bit          pend_a, pend_b, prefer_a, pin_host;
   logic [AW-1:0] addr_a_v, addr_b_v, h1, h2, h3;
   logic [DW-1:0] data_a_v, data_b_v;
   int          scan_left;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic exp_t mk(input int due, input logic [63:0] v);
      exp_t e;
      e.due = due;
      e.val = v;
      return e;
   endfunction

   // One cycle of the behavioural model, given the inputs applied in cycle c.
   task automatic model_step(input int c, input bit start);
      if (scan_left == 0) begin
         if (pend_a && (!pend_b || prefer_a)) begin
            gnt_q.push_back(mk(c, 64'd1));
            wr_q.push_back(mk(c + 1, 64'({addr_a_v, data_a_v})));
            pend_a   = 1'b0;
            prefer_a = 1'b0;
         end else if (pend_b) begin
            gnt_q.push_back(mk(c, 64'd2));
            wr_q.push_back(mk(c + 1, 64'({addr_b_v, data_b_v})));
            pend_b   = 1'b0;
            prefer_a = 1'b1;
         end
         if (start) begin
            for (int i = 0; i < DEPTH; i++)
               scan_q.push_back(mk(c + 1 + i,
                  64'({AW'(i), AW'(i), AW'((i / 4) * 4), AW'(0)})));
            done_q.push_back(mk(c + 1 + DEPTH, 64'd1));
            scan_left = DEPTH + 1;
         end else begin
            host_q.push_back(mk(c + 1, 64'({bus.host_r_s1, bus.host_r_s2, bus.host_r_s3})));
         end
      end else begin
         scan_left--;
      end
   endtask

   task automatic drive_cycle(input bit start, input bit rand_req);
      int c;
      @(posedge clk);
      #1;
      reset = 1'b0;
      c = cyc;
      if (rand_req && !pend_a && $urandom_range(0, 2) == 0) begin
         pend_a = 1'b1; addr_a_v = AW'($urandom); data_a_v = DW'($urandom);
      end
      if (rand_req && !pend_b && $urandom_range(0, 2) == 0) begin
         pend_b = 1'b1; addr_b_v = AW'($urandom); data_b_v = DW'($urandom);
      end
      bus.req_a  = pend_a;
      bus.addr_a = addr_a_v;
      bus.data_a = data_a_v;
      bus.req_b  = pend_b;
      bus.addr_b = addr_b_v;
      bus.data_b = data_b_v;
      bus.host_r_s1  = pin_host ? h1 : AW'($urandom);
      bus.host_r_s2  = pin_host ? h2 : AW'($urandom);
      bus.host_r_s3  = pin_host ? h3 : AW'($urandom);
      bus.scan_start = start;
      model_step(c, start);
   endtask

   // Asserts reset immediately, holds it across one edge, then checks zeros.
   task automatic do_reset();
      reset = 1'b1;
      bus.req_a = 1'b0; bus.req_b = 1'b0; bus.scan_start = 1'b0;
      bus.addr_a = '0; bus.addr_b = '0; bus.data_a = '0; bus.data_b = '0;
      bus.host_r_s1 = '0; bus.host_r_s2 = '0; bus.host_r_s3 = '0;
      pend_a = 1'b0; pend_b = 1'b0; prefer_a = 1'b1; scan_left = 0;
      gnt_q.delete(); wr_q.delete(); scan_q.delete(); done_q.delete(); host_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("rst_wr",   64'({bus.ram_wr_en, bus.ram_w_s, bus.ram_w_d}), 64'd0);
      check("rst_rd",   64'({bus.ram_r_s1, bus.ram_r_s2, bus.ram_r_s3}), 64'd0);
      check("rst_scan", 64'({bus.scan_idx, bus.scan_busy, bus.scan_done}), 64'd0);
      check("rst_gnt",  64'({bus.gnt_a, bus.gnt_b}), 64'd0);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset) begin
         if (bus.gnt_a || bus.gnt_b) begin
            check("gnt_onehot", 64'(bus.gnt_a & bus.gnt_b), 64'd0);
            if (gnt_q.size() == 0) check("gnt_unexpected", 64'({bus.gnt_b, bus.gnt_a}), 64'd0);
            else begin
               e = gnt_q.pop_front();
               check("gnt", {32'(cyc), 32'({bus.gnt_b, bus.gnt_a})}, {32'(e.due), e.val[31:0]});
            end
         end
         if (bus.ram_wr_en) begin
            if (wr_q.size() == 0) check("wr_unexpected", 64'(bus.ram_wr_en), 64'd0);
            else begin
               e = wr_q.pop_front();
               check("wr", {32'(cyc), 32'({bus.ram_w_s, bus.ram_w_d})}, {32'(e.due), e.val[31:0]});
            end
         end
         if (bus.scan_busy && !bus.scan_done) begin
            if (scan_q.size() == 0) check("scan_unexpected", 64'(bus.scan_busy), 64'd0);
            else begin
               e = scan_q.pop_front();
               check("scan_rd", {32'(cyc), 32'({bus.scan_idx, bus.ram_r_s1, bus.ram_r_s2, bus.ram_r_s3})},
                     {32'(e.due), e.val[31:0]});
            end
         end
         if (bus.scan_done) begin
            if (done_q.size() == 0) check("done_unexpected", 64'(bus.scan_done), 64'd0);
            else begin
               e = done_q.pop_front();
               check("scan_done", {32'(cyc), 32'(bus.scan_busy)}, {32'(e.due), e.val[31:0]});
            end
         end
         while (host_q.size() > 0 && host_q[0].due <= cyc) begin
            e = host_q.pop_front();
            check("host_rd", {32'(cyc), 32'({bus.ram_r_s1, bus.ram_r_s2, bus.ram_r_s3})},
                  {32'(e.due), e.val[31:0]});
         end
      end
   end

   initial begin
      pin_host = 1'b0;
      h1 = '0; h2 = '0; h3 = '0;
      addr_a_v = '0; addr_b_v = '0; data_a_v = '0; data_b_v = '0;
      do_reset();

      // Single write from A right after reset
      pend_a = 1'b1; addr_a_v = AW'(5); data_a_v = 8'hA5;
      repeat (3) drive_cycle(1'b0, 1'b0);

      // Contested requests held for 4 cycles
      do_reset();
      for (int k = 0; k < 4; k++) begin
         pend_a = 1'b1; addr_a_v = AW'(k);      data_a_v = DW'(8'h10 + k);
         pend_b = 1'b1; addr_b_v = AW'(k + 16); data_b_v = DW'(8'h20 + k);
         drive_cycle(1'b0, 1'b0);
      end
      drive_cycle(1'b0, 1'b0);

      // Host read latency with fixed addresses
      pin_host = 1'b1; h1 = AW'(7); h2 = AW'(9); h3 = AW'(3);
      repeat (2) drive_cycle(1'b0, 1'b0);
      pin_host = 1'b0;

      // Full scan; B requests mid-scan, extra scan_start pulses ignored
      drive_cycle(1'b1, 1'b0);
      for (int k = 1; k <= 36; k++) begin
         if (k == 5) begin pend_b = 1'b1; addr_b_v = AW'(21); data_b_v = 8'h3C; end
         drive_cycle(k == 10 || k == 20, 1'b0);
      end

      // Write request coinciding with scan_start
      pend_a = 1'b1; addr_a_v = AW'(30); data_a_v = 8'h5A;
      drive_cycle(1'b1, 1'b0);
      repeat (36) drive_cycle(1'b0, 1'b0);

      // Reset in the middle of a scan, then restart
      drive_cycle(1'b1, 1'b0);
      repeat (13) drive_cycle(1'b0, 1'b0);
      check("mid_idx", 64'(bus.scan_idx), 64'd12);
      do_reset();
      drive_cycle(1'b1, 1'b0);
      repeat (36) drive_cycle(1'b0, 1'b0);

      // Random traffic
      repeat (800) drive_cycle($urandom_range(0, 39) == 0, 1'b1);
      repeat (40) drive_cycle(1'b0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      #1;
      check("gnt_q_empty",  64'(gnt_q.size()),  64'd0);
      check("wr_q_empty",   64'(wr_q.size()),   64'd0);
      check("scan_q_empty", 64'(scan_q.size()), 64'd0);
      check("done_q_empty", 64'(done_q.size()), 64'd0);
      check("host_q_empty", 64'(host_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
